// File: rtl/stopwatch_core.sv
// MM:SS stopwatch: up/down counting on tickNORMAL, per-field adjust on tickADJ,
// pause toggle, lap freeze and a wrap pulse. All outputs come straight from flops.
module stopwatch_core #(
  parameter int WIDTH   = 6,
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             tickNORMAL,
  input  logic             tickADJ,
  input  logic             btnP,
  input  logic             btnL,
  input  logic             swADJ,
  input  logic             swSEL,
  input  logic             swDIR,
  output logic [WIDTH-1:0] minutes,
  output logic [WIDTH-1:0] seconds,
  output logic             paused,
  output logic             lapHold,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] SEC_TOP = WIDTH'(SEC_MAX);
  localparam logic [WIDTH-1:0] MIN_TOP = WIDTH'(MIN_MAX);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] sec_q, sec_d, min_q, min_d;
  logic [WIDTH-1:0] lap_sec_q, lap_sec_d, lap_min_q, lap_min_d;
  logic [WIDTH-1:0] disp_sec_q, disp_sec_d, disp_min_q, disp_min_d;
  logic             paused_q, paused_d, hold_q, hold_d, wrap_q, wrap_d;
  logic             btn_p_q, btn_l_q;
  logic             ev_p, ev_l;

  assign ev_p = btnP & ~btn_p_q;
  assign ev_l = btnL & ~btn_l_q;

  always_comb begin
    sec_d     = sec_q;
    min_d     = min_q;
    lap_sec_d = lap_sec_q;
    lap_min_d = lap_min_q;
    paused_d  = paused_q;
    hold_d    = hold_q;
    wrap_d    = 1'b0;

    // Every decision below looks only at pre-edge state, so a tick coinciding
    // with a pause press is still judged against the old paused value.
    if (!paused_q) begin
      if (!swADJ && tickNORMAL) begin
        if (!swDIR) begin
          if (sec_q < SEC_TOP) begin
            sec_d = sec_q + ONE;
          end else begin
            sec_d = '0;
            if (min_q < MIN_TOP) begin
              min_d = min_q + ONE;
            end else begin
              min_d  = '0;
              wrap_d = 1'b1;
            end
          end
        end else begin
          if (sec_q != '0) begin
            sec_d = sec_q - ONE;
          end else begin
            sec_d = SEC_TOP;
            if (min_q != '0) begin
              min_d = min_q - ONE;
            end else begin
              min_d  = MIN_TOP;
              wrap_d = 1'b1;
            end
          end
        end
      end else if (swADJ && tickADJ) begin
        if (swSEL) sec_d = (sec_q >= SEC_TOP) ? '0 : sec_q + ONE;
        else       min_d = (min_q >= MIN_TOP) ? '0 : min_q + ONE;
      end
    end

    if (ev_p) paused_d = ~paused_q;

    if (ev_l) begin
      if (!hold_q) begin
        lap_sec_d = sec_q;
        lap_min_d = min_q;
        hold_d    = 1'b1;
      end else begin
        hold_d    = 1'b0;
      end
    end

    disp_sec_d = hold_d ? lap_sec_d : sec_d;
    disp_min_d = hold_d ? lap_min_d : min_d;
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      sec_q      <= '0;
      min_q      <= '0;
      lap_sec_q  <= '0;
      lap_min_q  <= '0;
      disp_sec_q <= '0;
      disp_min_q <= '0;
      paused_q   <= 1'b0;
      hold_q     <= 1'b0;
      wrap_q     <= 1'b0;
      btn_p_q    <= 1'b0;
      btn_l_q    <= 1'b0;
    end else begin
      sec_q      <= sec_d;
      min_q      <= min_d;
      lap_sec_q  <= lap_sec_d;
      lap_min_q  <= lap_min_d;
      disp_sec_q <= disp_sec_d;
      disp_min_q <= disp_min_d;
      paused_q   <= paused_d;
      hold_q     <= hold_d;
      wrap_q     <= wrap_d;
      btn_p_q    <= btnP;
      btn_l_q    <= btnL;
    end
  end

  assign minutes = disp_min_q;
  assign seconds = disp_sec_q;
  assign paused  = paused_q;
  assign lapHold = hold_q;
  assign wrap    = wrap_q;

endmodule
